// File: rtl/pe_partial_sync.sv
// Partial-sum processing element: buffers one filter row and one ifmap row, then
// emits one sliding-window partial sum per output index toward the combining PE.
module pe_partial_sync #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 25,
    parameter int WEIGHT_WIDTH = 8,
    parameter int WPP          = 2,
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int SUM_WIDTH    = 13,
    parameter int IDX_W        = 5,
    parameter int PE_ID        = 0,
    parameter int DEST_ID      = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ADDR_W+1+DATA_W-1:0]        in_packet,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_W+IDX_W+SUM_WIDTH-1:0] out_packet,
    output logic                              weights_loaded,
    output logic                              busy,
    output logic                              drop_pulse
);
    localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int WC_W    = $clog2(FILTER_SIZE + 1);
    localparam int SC_W    = $clog2(IFMAP_SIZE + 1);
    localparam int INS_W   = IFMAP_SIZE + DATA_W;

    localparam logic [ADDR_W-1:0] PE_ADDR   = ADDR_W'(PE_ID);
    localparam logic [ADDR_W-1:0] DEST_ADDR = ADDR_W'(DEST_ID);
    localparam logic [WC_W-1:0]   WC_FULL   = WC_W'(FILTER_SIZE);
    localparam logic [SC_W-1:0]   SC_FULL   = SC_W'(IFMAP_SIZE);
    localparam logic [IDX_W-1:0]  J_LAST    = IDX_W'(OUT_DIM - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_SEND} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic signed [WEIGHT_WIDTH-1:0]  r_w [FILTER_SIZE];
    logic [IFMAP_SIZE-1:0]           r_spikes;
    logic [WC_W-1:0]                 r_wcnt;
    logic [SC_W-1:0]                 r_scnt;
    logic [IDX_W-1:0]                r_j;
    logic [ADDR_W+IDX_W+SUM_WIDTH-1:0] r_out_packet;
    logic                            r_drop;

    logic [ADDR_W-1:0]               w_dest;
    logic                            w_opcode;
    logic [DATA_W-1:0]               w_data;
    logic                            w_accept;
    logic                            w_addr_ok;
    logic                            w_wr_weight;
    logic                            w_wr_spike;
    logic                            w_drop;
    logic                            w_send_hs;
    logic                            w_row_done;
    logic [WC_W-1:0]                 w_wbase;
    logic [WC_W-1:0]                 w_wcnt_next;
    logic [SC_W-1:0]                 w_scnt_next;
    logic [IFMAP_SIZE-1:0]           w_sp_ins;
    logic [IFMAP_SIZE-1:0]           w_sp_mask;
    logic [FILTER_SIZE-1:0]          w_win;
    logic signed [SUM_WIDTH-1:0]     w_psum;

    assign {w_dest, w_opcode, w_data} = in_packet;

    assign w_accept    = in_valid && (r_state == ST_LOAD);
    assign w_addr_ok   = (w_dest == PE_ADDR);
    assign w_wr_weight = w_accept && w_addr_ok && !w_opcode;
    assign w_wr_spike  = w_accept && w_addr_ok && w_opcode && (r_scnt != SC_FULL);
    assign w_drop      = w_accept && (!w_addr_ok || (w_opcode && (r_scnt == SC_FULL)));
    assign w_send_hs   = (r_state == ST_SEND) && out_ready;
    assign w_row_done  = w_send_hs && (r_j == J_LAST);

    // A weight packet arriving with a full filter row starts a reload at w[0].
    assign w_wbase = (r_wcnt == WC_FULL) ? '0 : r_wcnt;

    // Spike payload lands at bit position scnt; bits past the row are truncated away.
    assign w_sp_ins  = IFMAP_SIZE'(INS_W'(w_data) << r_scnt);
    assign w_sp_mask = IFMAP_SIZE'(INS_W'({DATA_W{1'b1}}) << r_scnt);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_wcnt_next = r_wcnt;
        w_scnt_next = r_scnt;
        if (w_wr_weight) begin
            if (int'(w_wbase) + WPP >= FILTER_SIZE)
                w_wcnt_next = WC_FULL;
            else
                w_wcnt_next = w_wbase + WC_W'(WPP);
        end
        if (w_wr_spike) begin
            if (int'(r_scnt) + DATA_W >= IFMAP_SIZE)
                w_scnt_next = SC_FULL;
            else
                w_scnt_next = r_scnt + SC_W'(DATA_W);
        end
        if (w_row_done)
            w_scnt_next = '0;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if ((w_wcnt_next == WC_FULL) && (w_scnt_next == SC_FULL))
                    w_state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy         = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = (r_j == J_LAST) ? ST_LOAD : ST_COMPUTE;
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // Window of spikes starting at output index j, and its weighted sum.
    assign w_win = FILTER_SIZE'(r_spikes >> r_j);

    always_comb begin
        w_psum = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            if (w_win[k])
                w_psum = w_psum + SUM_WIDTH'(r_w[k]);
        end
    end

    // NOTE: sequential state uses non-blocking <= so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_wcnt  <= '0;
            r_scnt  <= '0;
            r_j     <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
            r_scnt  <= w_scnt_next;
            r_drop  <= w_drop;
            if (r_state == ST_LOAD)
                r_j <= '0;
            else if (w_send_hs && (r_j != J_LAST))
                r_j <= r_j + IDX_W'(1);
        end
    end

    // NOTE: the weight store is a handful of flops, so it is cleared by reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FILTER_SIZE; k++)
                r_w[k] <= '0;
        end else if (w_wr_weight) begin
            for (int k = 0; k < FILTER_SIZE; k++) begin
                for (int i = 0; i < WPP; i++) begin
                    if (k == int'(w_wbase) + i)
                        r_w[k] <= w_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_spikes <= '0;
        else if (w_wr_spike)
            r_spikes <= (r_spikes & ~w_sp_mask) | w_sp_ins;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_out_packet <= '0;
        else if (r_state == ST_COMPUTE)
            r_out_packet <= {DEST_ADDR, r_j, w_psum};
    end

    assign out_packet     = r_out_packet;
    assign weights_loaded = (r_wcnt == WC_FULL);
    assign drop_pulse     = r_drop;

endmodule

// File: tb/tb_pe_partial_sync.sv
// Directed bench for pe_partial_sync: table of row vectors with hand-computed partial
// sums, plus sequences for input-order, drops, output stall and mid-row reset.
`timescale 1ns/1ps
module tb_pe_partial_sync;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 25;
    localparam int WW      = 8;
    localparam int FS      = 5;
    localparam int SW      = 13;
    localparam int IDX_W   = 5;
    localparam int OUT_DIM = 21;
    localparam int PKT_W   = ADDR_W + 1 + DATA_W;
    localparam int OUT_W   = ADDR_W + IDX_W + SW;
    localparam logic [ADDR_W-1:0] PE   = 4'd0;
    localparam logic [ADDR_W-1:0] DEST = 4'd0;
    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] in_packet;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_packet;
    logic             weights_loaded;
    logic             busy;
    logic             drop_pulse;

    always #5 clk = ~clk;

    pe_partial_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEIGHT_WIDTH(WW), .WPP(2),
        .FILTER_SIZE(FS), .IFMAP_SIZE(25), .SUM_WIDTH(SW), .IDX_W(IDX_W),
        .PE_ID(0), .DEST_ID(0)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
        .weights_loaded(weights_loaded), .busy(busy), .drop_pulse(drop_pulse)
    );

    typedef logic [OUT_DIM-1:0][SW-1:0] row_t;
    typedef struct {
        logic                  reload;
        logic                  wl_before;
        logic [FS-1:0][WW-1:0] w;
        logic [DATA_W-1:0]     spikes;
        row_t                  exp;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] pkt(input logic [ADDR_W-1:0] dest, input logic op,
                                             input logic [DATA_W-1:0] data);
        return {dest, op, data};
    endfunction

    function automatic row_t const_row(input logic [SW-1:0] v);
        row_t r;
        for (int i = 0; i < OUT_DIM; i++) r[i] = v;
        return r;
    endfunction

    // Starts and ends on a falling edge; the handshake happens at the rising edge between.
    task automatic send_pkt(input logic [PKT_W-1:0] p);
        int n;
        n = 0;
        in_packet = p;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_weights(input logic [FS-1:0][WW-1:0] w);
        send_pkt(pkt(PE, 1'b0, {9'b0, w[1], w[0]}));
        check("weights_loaded_mid", {31'b0, weights_loaded}, 32'd0);
        send_pkt(pkt(PE, 1'b0, {9'b0, w[3], w[2]}));
        send_pkt(pkt(PE, 1'b0, {9'b0, 8'h55, w[4]}));
        check("weights_loaded_full", {31'b0, weights_loaded}, 32'd1);
    endtask

    task automatic expect_range(input row_t exp, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("out_valid[%0d]", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("dest[%0d]", i), 32'(out_packet[OUT_W-1 -: ADDR_W]), 32'(DEST));
            check($sformatf("idx[%0d]", i), 32'(out_packet[SW +: IDX_W]), 32'(i));
            check($sformatf("psum[%0d]", i), 32'(out_packet[SW-1:0]), 32'(exp[i]));
            @(negedge clk);
        end
    endtask

    // After the last input handshake: COMPUTE for one cycle, then SEND.
    task automatic check_latency();
        check("busy_compute", {31'b0, busy}, 32'd1);
        check("in_ready_compute", {31'b0, in_ready}, 32'd0);
        check("out_valid_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("out_valid_latency", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b1;

        // w = [1,-2,3,-4,5]: all ones -> 3 everywhere
        vecs[0].reload = 1'b1; vecs[0].wl_before = 1'b0;
        vecs[0].w      = {8'sd5, -8'sd4, 8'sd3, -8'sd2, 8'sd1};
        vecs[0].spikes = ONES;
        vecs[0].exp    = const_row(SW'(3));
        // single spike at bit 0 -> only idx0 sees w[0]
        vecs[1].reload = 1'b0; vecs[1].wl_before = 1'b1;
        vecs[1].w      = vecs[0].w;
        vecs[1].spikes = 25'h1;
        vecs[1].exp    = const_row('0);
        vecs[1].exp[0] = SW'(1);
        // spike at bit 4 -> idx j sees w[4-j]
        vecs[2].reload = 1'b0; vecs[2].wl_before = 1'b1;
        vecs[2].w      = vecs[0].w;
        vecs[2].spikes = 25'h10;
        vecs[2].exp    = const_row('0);
        vecs[2].exp[0] = SW'(5);
        vecs[2].exp[1] = SW'(-4);
        vecs[2].exp[2] = SW'(3);
        vecs[2].exp[3] = SW'(-2);
        vecs[2].exp[4] = SW'(1);
        // last spike only reaches the last window through w[4]
        vecs[3].reload = 1'b0; vecs[3].wl_before = 1'b1;
        vecs[3].w      = vecs[0].w;
        vecs[3].spikes = 25'h1000000;
        vecs[3].exp    = const_row('0);
        vecs[3].exp[20] = SW'(5);
        // odd bits set: even j -> w1+w3 = -6, odd j -> w0+w2+w4 = 9
        vecs[4].reload = 1'b0; vecs[4].wl_before = 1'b1;
        vecs[4].w      = vecs[0].w;
        vecs[4].spikes = 25'h0AAAAAA;
        for (int i = 0; i < OUT_DIM; i++)
            vecs[4].exp[i] = (i % 2 == 0) ? SW'(-6) : SW'(9);
        // reload with most negative weights: 5 * -128 = -640
        vecs[5].reload = 1'b1; vecs[5].wl_before = 1'b1;
        vecs[5].w      = {5{8'h80}};
        vecs[5].spikes = ONES;
        vecs[5].exp    = const_row(SW'(-640));
        // second row without reload reuses -128 weights
        vecs[6].reload = 1'b0; vecs[6].wl_before = 1'b1;
        vecs[6].w      = vecs[5].w;
        vecs[6].spikes = 25'h1;
        vecs[6].exp    = const_row('0);
        vecs[6].exp[0] = SW'(-128);

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_packet", 32'(out_packet), 32'd0);
        check("rst_weights_loaded", {31'b0, weights_loaded}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_drop_pulse", {31'b0, drop_pulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            check($sformatf("wl_before[v%0d]", v), {31'b0, weights_loaded}, {31'b0, vecs[v].wl_before});
            if (vecs[v].reload)
                load_weights(vecs[v].w);
            send_pkt(pkt(PE, 1'b1, vecs[v].spikes));
            check_latency();
            expect_range(vecs[v].exp, 0, OUT_DIM - 1);
            check($sformatf("in_ready_after[v%0d]", v), {31'b0, in_ready}, 32'd1);
            check($sformatf("busy_after[v%0d]", v), {31'b0, busy}, 32'd0);
        end

        // Spikes before weights, with a wrong-address packet and an overflow spike packet dropped.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_pkt(pkt(PE, 1'b1, 25'h1));
        check("spk_first_busy", {31'b0, busy}, 32'd0);
        check("spk_first_nodrop", {31'b0, drop_pulse}, 32'd0);
        send_pkt(pkt(4'h3, 1'b0, {9'b0, 8'h7F, 8'h7F}));
        check("drop_addr", {31'b0, drop_pulse}, 32'd1);
        @(negedge clk);
        check("drop_addr_end", {31'b0, drop_pulse}, 32'd0);
        send_pkt(pkt(PE, 1'b1, ONES));
        check("drop_full", {31'b0, drop_pulse}, 32'd1);
        check("drop_full_wl", {31'b0, weights_loaded}, 32'd0);
        check("drop_full_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("drop_full_end", {31'b0, drop_pulse}, 32'd0);
        load_weights(vecs[0].w);
        check_latency();
        expect_range(vecs[1].exp, 0, OUT_DIM - 1);

        // Output stall on idx 4, then release.
        send_pkt(pkt(PE, 1'b1, ONES));
        check_latency();
        expect_range(vecs[0].exp, 0, 3);
        out_ready = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_valid[%0d]", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall_pkt[%0d]", c), 32'(out_packet), 32'({DEST, 5'd4, 13'd3}));
            check($sformatf("stall_in_ready[%0d]", c), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_gap", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("release_next", {31'b0, out_valid}, 32'd1);
        expect_range(vecs[0].exp, 5, OUT_DIM - 1);

        // Reset during SEND of idx 7, then full reload.
        send_pkt(pkt(PE, 1'b1, ONES));
        check_latency();
        expect_range(vecs[0].exp, 0, 6);
        out_ready = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("pre_reset_idx", 32'(out_packet[SW +: IDX_W]), 32'd7);
        #1 reset = 1'b1;
        #1;
        check("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_reset_wl", {31'b0, weights_loaded}, 32'd0);
        check("mid_reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_reset_busy", {31'b0, busy}, 32'd0);
        check("mid_reset_out_packet", 32'(out_packet), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        load_weights(vecs[0].w);
        send_pkt(pkt(PE, 1'b1, ONES));
        check_latency();
        expect_range(vecs[0].exp, 0, OUT_DIM - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
